// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller. It issues imem requests from the current PC and
// holds the fetched word for decode. It pulses the PC +4 after each fetch and loads branch targets.
module fetch_ctrl #(
  parameter int unsigned RESET_HOLD = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_write_en,
  output logic        pc_load,
  output logic [31:0] pc_new,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DRAIN, REDIRECT} state_t;

  localparam int unsigned CW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  state_t        state, next;
  logic [CW-1:0] hold_cnt;
  logic          hold_done;
  logic [31:0]   pending;
  logic          inc_pulse;

  assign hold_done = (hold_cnt == CW'(RESET_HOLD - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  // A branch always beats a same-cycle ack; anything already requested must drain first.
  always_comb begin
    next = state;
    case (state)
      IDLE:     if (hold_done) next = ISSUE;
      ISSUE:    next = branch_taken ? DRAIN : WAIT;
      WAIT: begin
        if (branch_taken) next = imem_ack ? REDIRECT : DRAIN;
        else if (imem_ack) next = HOLD;
      end
      HOLD: begin
        if (branch_taken)  next = REDIRECT;
        else if (ir_ready) next = ISSUE;
      end
      DRAIN:    if (imem_ack) next = REDIRECT;
      REDIRECT: next = branch_taken ? REDIRECT : ISSUE;
      default:  next = IDLE;
    endcase
  end

  always_comb begin
    pc_write_en = inc_pulse || (state == REDIRECT);
    pc_load     = (state == REDIRECT);
    pc_new      = (state == REDIRECT) ? pending : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt  <= '0;
      pending   <= '0;
      inc_pulse <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      ir        <= '0;
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
    end else begin
      inc_pulse <= 1'b0;
      hold_cnt  <= (state == IDLE) ? hold_cnt + CW'(1) : '0;
      if (state != IDLE && branch_taken) begin
        pending  <= branch_target & ~32'h3;
        ir_valid <= 1'b0;
      end
      case (state)
        ISSUE: begin
          imem_req  <= 1'b1;
          imem_addr <= pc_in;
        end
        WAIT: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            if (!branch_taken) begin
              ir        <= imem_rdata;
              ir_pc     <= imem_addr;
              ir_valid  <= 1'b1;
              inc_pulse <= 1'b1;
            end
          end
        end
        HOLD:    if (ir_ready && !branch_taken) ir_valid <= 1'b0;
        DRAIN:   if (imem_ack) imem_req <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a behavioural PC, a latency-configurable instruction memory,
// and a transaction monitor whose logs are checked against address-sequence expectations.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_in;
  logic        pc_write_en, pc_load;
  logic [31:0] pc_new;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [31:0] ir, ir_pc;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_HOLD(1)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in),
    .pc_write_en(pc_write_en), .pc_load(pc_load), .pc_new(pc_new),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc),
    .branch_taken(branch_taken), .branch_target(branch_target)
  );

  // Program counter block
  always @(posedge clk) begin
    if (reset)            pc_in <= '0;
    else if (pc_write_en) pc_in <= pc_load ? pc_new : pc_in + 32'd4;
  end

  // Instruction memory: ack after mem_lat cycles of a held request, data = 0xA0000000+addr
  int unsigned mem_lat = 2;
  bit          rand_lat = 1'b0;
  int unsigned mem_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (!imem_req) begin
      mem_cnt  = 0;
      imem_ack = 1'b0;
    end else begin
      if (mem_cnt == 0 && rand_lat) mem_lat = $urandom_range(1, 4);
      mem_cnt++;
      imem_ack   = (mem_cnt >= mem_lat);
      imem_rdata = imem_ack ? 32'hA000_0000 + imem_addr : 32'hDEAD_BEEF;
    end
  end

  // Transaction monitor
  logic [31:0] fetch_q[$];
  logic [31:0] acc_addr_q[$];
  logic [31:0] acc_data_q[$];
  logic [31:0] load_q[$];
  int          inc_cnt = 0;
  int          addr_err = 0;
  logic        req_prev = 1'b0;
  logic [31:0] addr_prev = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if (imem_req && !req_prev) fetch_q.push_back(imem_addr);
      if (imem_req && req_prev && imem_addr !== addr_prev) addr_err++;
      if (ir_valid && ir_ready && !branch_taken) begin
        acc_addr_q.push_back(ir_pc);
        acc_data_q.push_back(ir);
      end
      if (pc_write_en && !pc_load) inc_cnt++;
      if (pc_write_en && pc_load) load_q.push_back(pc_new);
    end
    req_prev  = imem_req;
    addr_prev = imem_addr;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    fetch_q.delete();
    acc_addr_q.delete();
    acc_data_q.delete();
    load_q.delete();
    inc_cnt  = 0;
    addr_err = 0;
  endtask

  task automatic do_reset(input int unsigned lat);
    reset         = 1'b1;
    branch_taken  = 1'b0;
    branch_target = '0;
    ir_ready      = 1'b0;
    rand_lat      = 1'b0;
    mem_lat       = lat;
    repeat (3) step();
    clear_mon();
    reset = 1'b0;
  endtask

  task automatic wait_fetch(input int n, output bit ok);
    int b = 0;
    while (fetch_q.size() < n && b < 300) begin step(); b++; end
    ok = (fetch_q.size() >= n);
  endtask

  task automatic wait_acc(input int n, input int budget, output bit ok);
    int b = 0;
    while (acc_addr_q.size() < n && b < budget) begin step(); b++; end
    ok = (acc_addr_q.size() >= n);
  endtask

  task automatic wait_valid(output bit ok);
    int b = 0;
    while (!ir_valid && b < 300) begin step(); b++; end
    ok = ir_valid;
  endtask

  task automatic wait_req(output bit ok);
    int b = 0;
    while (!imem_req && b < 300) begin step(); b++; end
    ok = imem_req;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ir_ready = 1'b0;
    branch_taken = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({pc_write_en, pc_load, imem_req, ir_valid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {pc_write_en, pc_load, imem_req, ir_valid});
    end
    n_checks++;
    if ((imem_addr | ir | ir_pc | pc_new) !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: addr=%h ir=%h ir_pc=%h pc_new=%h expected all 0", imem_addr, ir, ir_pc, pc_new);
    end
    clear_mon();
    reset = 1'b0;
    step();
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_e0_req: got %b expected 0", imem_req);
    end
    step();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_e1_req: req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_fetch_seq();
    bit ok;
    do_reset(2);
    ir_ready = 1'b1;
    wait_acc(3, 300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL seq_timeout: got %0d accepts expected 3", acc_addr_q.size()); end
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (fetch_q[i] !== 32'(4 * i)) begin
          n_fail++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, fetch_q[i], 32'(4 * i));
        end
        n_checks++;
        if (acc_addr_q[i] !== 32'(4 * i) || acc_data_q[i] !== 32'hA000_0000 + 32'(4 * i)) begin
          n_fail++; $display("FAIL seq_ir[%0d]: got pc=%h ir=%h expected pc=%h ir=%h", i,
                             acc_addr_q[i], acc_data_q[i], 32'(4 * i), 32'hA000_0000 + 32'(4 * i));
        end
      end
    end
    n_checks++;
    if (inc_cnt !== 3 || load_q.size() !== 0) begin
      n_fail++; $display("FAIL seq_pulses: got inc=%0d load=%0d expected inc=3 load=0", inc_cnt, load_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad = 0;
    logic [31:0] ir0, pc0;
    do_reset(2);
    ir_ready = 1'b0;
    wait_valid(ok);
    ir0 = ir;
    pc0 = ir_pc;
    n_checks++;
    if (!ok || pc0 !== 32'h0 || ir0 !== 32'hA000_0000) begin
      n_fail++; $display("FAIL bp_first: valid=%b pc=%h ir=%h expected 1 0 a0000000", ok, pc0, ir0);
    end
    repeat (5) begin
      step();
      if (ir !== ir0 || ir_pc !== pc0 || ir_valid !== 1'b1 || imem_req !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
    ir_ready = 1'b1;
    wait_fetch(2, ok);
    n_checks++;
    if (!ok || fetch_q[1] !== pc0 + 32'd4) begin
      n_fail++; $display("FAIL bp_next_addr: got %h expected %h", ok ? fetch_q[1] : 32'hx, pc0 + 32'd4);
    end
    n_checks++;
    if (acc_addr_q.size() < 1 || acc_addr_q[0] !== pc0) begin
      n_fail++; $display("FAIL bp_accept: got %0d accepts expected first pc %h", acc_addr_q.size(), pc0);
    end
  endtask

  task automatic test_branch_hold();
    bit ok;
    do_reset(2);
    ir_ready = 1'b0;
    wait_valid(ok);
    step();
    step();
    branch_taken  = 1'b1;
    branch_target = 32'h103;
    ir_ready      = 1'b1;
    step();
    branch_taken = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL bh_valid: got %b expected 0", ir_valid); end
    n_checks++;
    if (pc_write_en !== 1'b1 || pc_load !== 1'b1 || pc_new !== 32'h100) begin
      n_fail++; $display("FAIL bh_redirect: we=%b load=%b new=%h expected 1 1 00000100", pc_write_en, pc_load, pc_new);
    end
    wait_fetch(2, ok);
    n_checks++;
    if (!ok || fetch_q[1] !== 32'h100) begin
      n_fail++; $display("FAIL bh_target: got %h expected 00000100", ok ? fetch_q[1] : 32'hx);
    end
    wait_acc(1, 300, ok);
    n_checks++;
    if (!ok || acc_addr_q[0] !== 32'h100 || acc_data_q[0] !== 32'hA000_0100) begin
      n_fail++; $display("FAIL bh_accept: got pc=%h ir=%h expected 00000100 a0000100",
                         ok ? acc_addr_q[0] : 32'hx, ok ? acc_data_q[0] : 32'hx);
    end
  endtask

  task automatic test_branch_wait();
    bit ok;
    int held = 0;
    do_reset(3);
    ir_ready = 1'b1;
    wait_req(ok);
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    step();
    if (imem_req === 1'b1) held++;
    branch_target = 32'h300;
    step();
    if (imem_req === 1'b1) held++;
    branch_taken = 1'b0;
    n_checks++;
    if (!ok || held != 2) begin n_fail++; $display("FAIL bw_req_held: got %0d held cycles expected 2", held); end
    wait_fetch(2, ok);
    n_checks++;
    if (!ok || fetch_q[1] !== 32'h300) begin
      n_fail++; $display("FAIL bw_target: got %h expected 00000300", ok ? fetch_q[1] : 32'hx);
    end
    n_checks++;
    if (inc_cnt != 0 || acc_addr_q.size() != 0) begin
      n_fail++; $display("FAIL bw_discard: got inc=%0d accepts=%0d expected 0 0", inc_cnt, acc_addr_q.size());
    end
    n_checks++;
    if (load_q.size() != 1 || load_q[0] !== 32'h300) begin
      n_fail++; $display("FAIL bw_load: got %0d loads first=%h expected 1 load of 00000300",
                         load_q.size(), load_q.size() > 0 ? load_q[0] : 32'hx);
    end
  endtask

  task automatic test_branch_ack();
    bit ok;
    int b = 0;
    logic [31:0] tgt, exp_tgt;
    do_reset(2);
    ir_ready = 1'b1;
    tgt      = $urandom | 32'h1;
    exp_tgt  = {tgt[31:2], 2'b00};
    while (!imem_ack && b < 300) begin step(); b++; end
    branch_taken  = 1'b1;
    branch_target = tgt;
    step();
    branch_taken = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b0 || pc_load !== 1'b1 || pc_new !== exp_tgt) begin
      n_fail++; $display("FAIL ba_redirect: valid=%b load=%b new=%h expected 0 1 %h", ir_valid, pc_load, pc_new, exp_tgt);
    end
    wait_fetch(2, ok);
    n_checks++;
    if (!ok || fetch_q[1] !== exp_tgt) begin
      n_fail++; $display("FAIL ba_target: got %h expected %h", ok ? fetch_q[1] : 32'hx, exp_tgt);
    end
    n_checks++;
    if (inc_cnt != 0 || acc_addr_q.size() != 0) begin
      n_fail++; $display("FAIL ba_discard: got inc=%0d accepts=%0d expected 0 0", inc_cnt, acc_addr_q.size());
    end
  endtask

  task automatic test_reset_wait();
    bit ok;
    do_reset(4);
    ir_ready = 1'b1;
    wait_req(ok);
    step();
    reset = 1'b1;
    step();
    clear_mon();
    n_checks++;
    if ({pc_write_en, pc_load, imem_req, ir_valid} !== 4'b0 || (imem_addr | ir | ir_pc | pc_new) !== 32'h0) begin
      n_fail++; $display("FAIL rw_outputs: ctrl=%b addr=%h ir=%h ir_pc=%h expected all 0",
                         {pc_write_en, pc_load, imem_req, ir_valid}, imem_addr, ir, ir_pc);
    end
    reset = 1'b0;
    wait_fetch(1, ok);
    n_checks++;
    if (!ok || fetch_q[0] !== 32'h0) begin
      n_fail++; $display("FAIL rw_resume: got %h expected 00000000", ok ? fetch_q[0] : 32'hx);
    end
  endtask

  task automatic test_random();
    int b = 0;
    do_reset(2);
    rand_lat = 1'b1;
    while (acc_addr_q.size() < 20 && b < 3000) begin
      ir_ready = 1'($urandom_range(0, 1));
      step();
      b++;
    end
    ir_ready = 1'b0;
    rand_lat = 1'b0;
    n_checks++;
    if (acc_addr_q.size() < 20) begin
      n_fail++; $display("FAIL rnd_timeout: got %0d accepts expected 20", acc_addr_q.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        n_checks++;
        if (fetch_q[i] !== 32'(4 * i) || acc_addr_q[i] !== 32'(4 * i) || acc_data_q[i] !== 32'hA000_0000 + 32'(4 * i)) begin
          n_fail++; $display("FAIL rnd_txn[%0d]: got addr=%h pc=%h ir=%h expected addr=pc=%h ir=%h", i,
                             fetch_q[i], acc_addr_q[i], acc_data_q[i], 32'(4 * i), 32'hA000_0000 + 32'(4 * i));
        end
      end
    end
    n_checks++;
    if (inc_cnt < acc_addr_q.size() || inc_cnt > acc_addr_q.size() + 1 || load_q.size() != 0) begin
      n_fail++; $display("FAIL rnd_pulses: got inc=%0d loads=%0d expected inc=%0d..%0d loads=0",
                         inc_cnt, load_q.size(), acc_addr_q.size(), acc_addr_q.size() + 1);
    end
    n_checks++;
    if (addr_err != 0) begin n_fail++; $display("FAIL rnd_addr_stable: got %0d changes expected 0", addr_err); end
  endtask

  initial begin
    test_reset();
    test_fetch_seq();
    test_backpressure();
    test_branch_hold();
    test_branch_wait();
    test_branch_ack();
    test_reset_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
